lemming_arena: RTL and testbench

Behavioural environment model that closes the loop around the lemming walker FSM. It consumes the walker's `walk_left` and `walk_right` outputs, tracks the lemming's cell position in a 1-D arena bounded by walls, and generates the `bump_left` and `bump_right` pulses that the walker reacts to. It is used in the lemming subsystem as the walker's stimulus partner in system-level simulation and on the demo board.

---
 rtl/lemming_pkg.sv | 23 ++
 rtl/arena_wall_detect.sv | 37 +++
 rtl/lemming_arena.sv | 139 +++++++++++++
 tb/tb_lemming_arena.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/lemming_pkg.sv
// Shared types for the lemming subsystem: arena FSM states and the
// {walk_left, walk_right} direction encoding used by walker and arena.
package lemming_pkg;

   typedef enum logic [1:0] {
      ROAM   = 2'd0,
      WAIT_L = 2'd1,
      WAIT_R = 2'd2
   } arena_state_t;

   // Bit order is {walk_left, walk_right}.
   typedef enum logic [1:0] {
      DIR_NONE  = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_BOTH  = 2'b11
   } dir_t;

   function automatic dir_t to_dir(input logic walk_left, input logic walk_right);
      return dir_t'({walk_left, walk_right});
   endfunction

endpackage

// File: rtl/arena_wall_detect.sv
// Combinational wall/obstacle hit detection for the lemming arena.
// Only a legal single direction can produce a hit.
module arena_wall_detect
   import lemming_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                     walk_left,
   input  logic                     walk_right,
   input  logic [$clog2(WIDTH)-1:0] pos,
   input  logic                     obs_valid,
   input  logic [$clog2(WIDTH)-1:0] obs_pos,
   output logic                     hit_left,
   output logic                     hit_right
);

   localparam int POS_W = $clog2(WIDTH);

   dir_t           dir;
   logic [POS_W:0] pos_x;
   logic [POS_W:0] obs_x;

   // One extra bit so obs_pos+1 and pos+1 cannot wrap around the arena.
   assign dir   = to_dir(walk_left, walk_right);
   assign pos_x = {1'b0, pos};
   assign obs_x = {1'b0, obs_pos};

   always_comb begin
      hit_left  = 1'b0;
      hit_right = 1'b0;
      if (dir == DIR_LEFT)
         hit_left  = (pos == '0) || (obs_valid && (pos_x == obs_x + 1'b1));
      if (dir == DIR_RIGHT)
         hit_right = (pos == POS_W'(WIDTH - 1)) || (obs_valid && (pos_x + 1'b1 == obs_x));
   end

endmodule

// File: rtl/lemming_arena.sv
// 1-D arena model closing the loop around the lemming walker: tracks position,
// issues bump pulses and re-pulses them. Optional obstacle: LEMMING_ARENA_OBSTACLE_EN.
module lemming_arena
   import lemming_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8,
   parameter int RETRY = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     step_en,
   input  logic                     walk_left,
   input  logic                     walk_right,
`ifdef LEMMING_ARENA_OBSTACLE_EN
   input  logic                     obs_load,
   input  logic [$clog2(WIDTH)-1:0] obs_pos,
`endif
   output logic                     bump_left,
   output logic                     bump_right,
   output logic [$clog2(WIDTH)-1:0] pos,
   output logic [CNT_W-1:0]         bump_cnt,
   output logic                     dir_err
);

   localparam int POS_W   = $clog2(WIDTH);
   localparam int RETRY_W = (RETRY > 1) ? $clog2(RETRY) : 1;

   arena_state_t       state_q;
   logic [POS_W-1:0]   pos_q;
   logic [RETRY_W-1:0] retry_q;
   logic [CNT_W-1:0]   bump_cnt_q;
   logic [CNT_W-1:0]   bump_cnt_d;
   logic               bump_left_q;
   logic               bump_right_q;
   logic               dir_err_q;
   logic               obs_valid_q;
   logic [POS_W-1:0]   obs_pos_q;
   logic               hit_left;
   logic               hit_right;
   dir_t               dir;
   logic               retry_due;

`ifdef LEMMING_ARENA_OBSTACLE_EN
   // A load onto the lemming's own cell would trap it, so it is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         obs_valid_q <= 1'b0;
         obs_pos_q   <= '0;
      end else if (obs_load && (obs_pos != pos_q)) begin
         obs_valid_q <= 1'b1;
         obs_pos_q   <= obs_pos;
      end
   end
`else
   assign obs_valid_q = 1'b0;
   assign obs_pos_q   = '0;
`endif

   arena_wall_detect #(.WIDTH(WIDTH)) u_wall_detect (
      .walk_left  (walk_left),
      .walk_right (walk_right),
      .pos        (pos_q),
      .obs_valid  (obs_valid_q),
      .obs_pos    (obs_pos_q),
      .hit_left   (hit_left),
      .hit_right  (hit_right)
   );

   assign dir        = to_dir(walk_left, walk_right);
   assign bump_cnt_d = (bump_cnt_q == '1) ? bump_cnt_q : bump_cnt_q + 1'b1;
   assign retry_due  = (retry_q == RETRY_W'(RETRY - 1));

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values, keeping the single-block FSM race-free.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ROAM;
         pos_q        <= POS_W'(WIDTH / 2);
         retry_q      <= '0;
         bump_cnt_q   <= '0;
         bump_left_q  <= 1'b0;
         bump_right_q <= 1'b0;
         dir_err_q    <= 1'b0;
      end else begin
         bump_left_q  <= 1'b0;
         bump_right_q <= 1'b0;
         dir_err_q    <= (dir == DIR_NONE) || (dir == DIR_BOTH);
         case (state_q)
            ROAM: begin
               retry_q <= '0;
               if (hit_left) begin
                  bump_left_q <= 1'b1;
                  bump_cnt_q  <= bump_cnt_d;
                  state_q     <= WAIT_L;
               end else if (hit_right) begin
                  bump_right_q <= 1'b1;
                  bump_cnt_q   <= bump_cnt_d;
                  state_q      <= WAIT_R;
               end else if (step_en && (dir == DIR_LEFT)) begin
                  pos_q <= pos_q - 1'b1;
               end else if (step_en && (dir == DIR_RIGHT)) begin
                  pos_q <= pos_q + 1'b1;
               end
            end
            WAIT_L: begin
               if (!walk_left) begin
                  state_q <= ROAM;
               end else if (retry_due) begin
                  bump_left_q <= 1'b1;
                  bump_cnt_q  <= bump_cnt_d;
                  retry_q     <= '0;
               end else begin
                  retry_q <= retry_q + 1'b1;
               end
            end
            WAIT_R: begin
               if (!walk_right) begin
                  state_q <= ROAM;
               end else if (retry_due) begin
                  bump_right_q <= 1'b1;
                  bump_cnt_q   <= bump_cnt_d;
                  retry_q      <= '0;
               end else begin
                  retry_q <= retry_q + 1'b1;
               end
            end
            default: state_q <= ROAM;
         endcase
      end
   end

   assign bump_left  = bump_left_q;
   assign bump_right = bump_right_q;
   assign pos        = pos_q;
   assign bump_cnt   = bump_cnt_q;
   assign dir_err    = dir_err_q;

endmodule

// File: tb/tb_lemming_arena.sv
// Directed bench for lemming_arena (WIDTH=16, CNT_W=3, RETRY=4): vector table
// plus hand sequences for retry, saturation and reset-in-WAIT.
module tb_lemming_arena;

   logic       clk = 1'b0;
   logic       reset;
   logic       step_en;
   logic       walk_left;
   logic       walk_right;
   logic       bump_left;
   logic       bump_right;
   logic [3:0] pos;
   logic [2:0] bump_cnt;
   logic       dir_err;
`ifdef LEMMING_ARENA_OBSTACLE_EN
   logic       obs_load = 1'b0;
   logic [3:0] obs_pos  = '0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       rst;
      logic       step;
      logic       wl;
      logic       wr;
      logic       bl;
      logic       br;
      logic [3:0] pos;
      logic [2:0] cnt;
      logic       derr;
   } vec_t;

   vec_t vecs[$];

   lemming_arena #(.WIDTH(16), .CNT_W(3), .RETRY(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .step_en    (step_en),
      .walk_left  (walk_left),
      .walk_right (walk_right),
`ifdef LEMMING_ARENA_OBSTACLE_EN
      .obs_load   (obs_load),
      .obs_pos    (obs_pos),
`endif
      .bump_left  (bump_left),
      .bump_right (bump_right),
      .pos        (pos),
      .bump_cnt   (bump_cnt),
      .dir_err    (dir_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, s, l, rr, bl, br, input int p, input int c, input logic de);
      vec_t v;
      v.rst = r;  v.step = s; v.wl = l; v.wr = rr;
      v.bl  = bl; v.br = br;  v.pos = 4'(p); v.cnt = 3'(c); v.derr = de;
      vecs.push_back(v);
   endtask

   task automatic cycle(input logic r, s, l, rr);
      reset = r; step_en = s; walk_left = l; walk_right = rr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_cnt;
      logic exp_bl;

      reset = 1'b1; step_en = 1'b0; walk_left = 1'b0; walk_right = 1'b0;

      // Reset, walk left to the wall, bump, flip, walk right to the wall.
      add(1, 0, 0, 0, 0, 0, 8, 0, 0);
      for (int i = 1; i <= 8; i++) add(0, 1, 1, 0, 0, 0, 8 - i, 0, 0);
      add(0, 1, 1, 0, 1, 0, 0, 1, 0);
      add(0, 1, 0, 1, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 15; i++) add(0, 1, 0, 1, 0, 0, i, 1, 0);
      add(0, 1, 0, 1, 0, 1, 15, 2, 0);
      add(0, 1, 0, 0, 0, 0, 15, 2, 1);
      add(0, 1, 1, 1, 0, 0, 15, 2, 1);
      add(0, 1, 1, 0, 0, 0, 14, 2, 0);
      add(0, 0, 1, 0, 0, 0, 14, 2, 0);
      add(1, 1, 1, 0, 0, 0, 8, 0, 0);

      foreach (vecs[i]) begin
         cycle(vecs[i].rst, vecs[i].step, vecs[i].wl, vecs[i].wr);
         check($sformatf("vec%0d bump_left", i), 32'(bump_left), 32'(vecs[i].bl));
         check($sformatf("vec%0d bump_right", i), 32'(bump_right), 32'(vecs[i].br));
         check($sformatf("vec%0d pos", i), 32'(pos), 32'(vecs[i].pos));
         check($sformatf("vec%0d bump_cnt", i), 32'(bump_cnt), 32'(vecs[i].cnt));
         check($sformatf("vec%0d dir_err", i), 32'(dir_err), 32'(vecs[i].derr));
      end

      // Stuck walk_left at the left wall: re-pulse every 4 cycles, counter saturates at 7.
      for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0);
      check("stuck start pos", 32'(pos), 32'd0);
      exp_cnt = 0;
      for (int k = 1; k <= 29; k++) begin
         cycle(0, 1, 1, 0);
         exp_bl = (k % 4 == 1);
         if (exp_bl && exp_cnt < 7) exp_cnt++;
         check($sformatf("stuck%0d bump_left", k), 32'(bump_left), 32'(exp_bl));
         check($sformatf("stuck%0d bump_right", k), 32'(bump_right), 32'd0);
         check($sformatf("stuck%0d pos", k), 32'(pos), 32'd0);
         check($sformatf("stuck%0d bump_cnt", k), 32'(bump_cnt), 32'(exp_cnt));
         if (k == 9) check("three pulses after 9 cycles", 32'(bump_cnt), 32'd3);
      end
      check("bump_cnt saturated", 32'(bump_cnt), 32'd7);
      cycle(0, 1, 0, 1);
      check("wait_l exit holds pos", 32'(pos), 32'd0);
      cycle(0, 1, 0, 1);
      check("roam after wait_l", 32'(pos), 32'd1);

      // Reset during WAIT_R at pos 15, then confirm ROAM by a left step.
      for (int i = 0; i < 14; i++) cycle(0, 1, 0, 1);
      check("reach right wall", 32'(pos), 32'd15);
      cycle(0, 1, 0, 1);
      check("right bump", 32'(bump_right), 32'd1);
      cycle(1, 1, 0, 1);
      check("reset in wait pos", 32'(pos), 32'd8);
      check("reset in wait cnt", 32'(bump_cnt), 32'd0);
      check("reset in wait bump", 32'(bump_right), 32'd0);
      cycle(0, 1, 1, 0);
      check("roam after reset", 32'(pos), 32'd7);

      // Reset on the edge that would issue a bump: reset wins.
      for (int i = 0; i < 7; i++) cycle(0, 1, 1, 0);
      check("at left wall again", 32'(pos), 32'd0);
      cycle(1, 1, 1, 0);
      check("reset over bump pulse", 32'(bump_left), 32'd0);
      check("reset over bump pos", 32'(pos), 32'd8);
      check("reset over bump cnt", 32'(bump_cnt), 32'd0);

`ifdef LEMMING_ARENA_OBSTACLE_EN
      // Obstacle at cell 10: walking right from 8 bumps at 9.
      obs_pos = 4'd10; obs_load = 1'b1;
      cycle(0, 0, 0, 1);
      obs_load = 1'b0;
      cycle(0, 1, 0, 1);
      check("obs approach pos", 32'(pos), 32'd9);
      cycle(0, 1, 0, 1);
      check("obs bump_right", 32'(bump_right), 32'd1);
      check("obs bump pos", 32'(pos), 32'd9);
      cycle(0, 1, 0, 1);
      cycle(0, 1, 0, 1);
      check("obs never entered", 32'(pos), 32'd9);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
